// File: rtl/phase_capture.sv
// phase_capture
//   Receive-side phase meter for a transducer square wave. A local reference
//   counter runs at the same divide as the drive clock generator. Each rising
//   edge of the synchronised input is stamped with the reference phase, with
//   the synchroniser delay backed out. The result is emitted in the drive
//   generator's offset encoding so it can be written straight into a drive
//   channel. The input period is also checked, and lock is reported.
// Ports
//   clk        system clock
//   rst        asynchronous reset, active high
//   divide     half-period length minus 1
//   ref_sync   one-cycle pulse, realigns the reference counter to 0
//   sig_in     asynchronous receive square wave
//   offset_out {enable, half, count} of the last captured edge
//   valid      one-cycle pulse when offset_out updates
//   locked     input period stable for LOCK_COUNT periods
//   period_err one-cycle pulse on a bad period or on a timeout
module phase_capture #(
   parameter int OFFSET_WIDTH = 12,
   parameter int SYNC_STAGES  = 2,
   parameter int LOCK_COUNT   = 4,
   parameter int TOL          = 4
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic [OFFSET_WIDTH-3:0] divide,
   input  logic                    ref_sync,
   input  logic                    sig_in,
   output logic [OFFSET_WIDTH-1:0] offset_out,
   output logic                    valid,
   output logic                    locked,
   output logic                    period_err
);
   localparam int CW = OFFSET_WIDTH - 2;  // phase count width
   localparam int PW = OFFSET_WIDTH + 1;  // period counter width, holds 2*P
   localparam int XW = PW + 1;            // headroom for compares
   localparam int LW = $clog2(LOCK_COUNT + 1);
   localparam logic [CW-1:0] SYNC_C = CW'(SYNC_STAGES);
   localparam logic [LW-1:0] LOCK_C = LW'(LOCK_COUNT);

   logic [CW-1:0]          cnt;
   logic                   half;
   logic [SYNC_STAGES-1:0] sync_q;
   logic                   s_prev;
   logic                   rise;
   logic [CW-1:0]          cap_c;
   logic                   cap_h;
   logic [PW-1:0]          per_cnt;
   logic [PW-1:0]          per_exp;
   logic [PW-1:0]          per_tmo;
   logic                   tmo_hold;
   logic                   first;
   logic [LW-1:0]          lock_cnt;
   logic                   good;
   logic                   timeout;

   // Reference counter; ref_sync has priority over the natural wrap.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt  <= '0;
         half <= 1'b0;
      end else if (ref_sync) begin
         cnt  <= '0;
         half <= 1'b0;
      end else if (cnt == divide) begin
         cnt  <= '0;
         half <= ~half;
      end else begin
         cnt  <= cnt + CW'(1);
      end
   end

   // Input synchroniser plus one edge flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync_q <= '0;
         s_prev <= 1'b0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
         s_prev <= sync_q[SYNC_STAGES-1];
      end
   end

   assign rise = sync_q[SYNC_STAGES-1] & ~s_prev;

   // Back the stamp out by the synchroniser depth. If that crosses a
   // half-period boundary, borrow a full half-period and flip the level.
   always_comb begin
      cap_c = cnt - SYNC_C;
      cap_h = half;
      if (cnt < SYNC_C) begin
         cap_c = cnt + divide + CW'(1) - SYNC_C;
         cap_h = ~half;
      end
   end

   // Expected period P = 2*(divide+1); timeout threshold 2*P.
   assign per_exp = PW'({divide, 1'b0}) + PW'(2);
   assign per_tmo = {per_exp[PW-2:0], 1'b0};

   assign good = ({1'b0, per_cnt} + XW'(TOL) >= {1'b0, per_exp}) &&
                 ({1'b0, per_cnt} <= {1'b0, per_exp} + XW'(TOL));

   // Fires once as the counter reaches 2*P; tmo_hold freezes it afterwards.
   assign timeout = ~rise & ~tmo_hold &
                    ({1'b0, per_cnt} + XW'(1) >= {1'b0, per_tmo});

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         offset_out <= '0;
         valid      <= 1'b0;
         locked     <= 1'b0;
         period_err <= 1'b0;
         per_cnt    <= '0;
         tmo_hold   <= 1'b0;
         first      <= 1'b1;
         lock_cnt   <= '0;
      end else begin
         valid      <= rise;
         period_err <= 1'b0;
         if (rise) begin
            offset_out <= {1'b1, cap_h, cap_c};
            per_cnt    <= PW'(1);
            tmo_hold   <= 1'b0;
            if (first) begin
               first <= 1'b0;
            end else if (good) begin
               if (lock_cnt < LOCK_C) lock_cnt <= lock_cnt + LW'(1);
               if (lock_cnt >= LOCK_C - LW'(1)) locked <= 1'b1;
            end else begin
               lock_cnt   <= '0;
               locked     <= 1'b0;
               period_err <= 1'b1;
            end
         end else if (timeout) begin
            per_cnt    <= per_cnt + PW'(1);
            tmo_hold   <= 1'b1;
            locked     <= 1'b0;
            lock_cnt   <= '0;
            first      <= 1'b1;
            period_err <= 1'b1;
         end else if (!tmo_hold) begin
            per_cnt    <= per_cnt + PW'(1);
         end
      end
   end
endmodule

// File: tb/tb_phase_capture.sv
// tb_phase_capture
//   Directed bench for phase_capture (W=12, divide=624, SYNC_STAGES=2).
//   Each driven edge pushes its expected capture word, lock state and
//   period_err onto a queue; the valid pulse pops and compares it.
module tb_phase_capture;
   localparam int P     = 1250;
   localparam int TOL   = 4;
   localparam int LOCKN = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        ref_sync = 1'b0;
   logic        sig_in = 1'b0;
   logic [9:0]  divide = 10'd624;
   logic [11:0] offset_out;
   logic        valid;
   logic        locked;
   logic        period_err;

   phase_capture #(
      .OFFSET_WIDTH(12), .SYNC_STAGES(2), .LOCK_COUNT(LOCKN), .TOL(TOL)
   ) dut (
      .clk(clk), .rst(rst), .divide(divide), .ref_sync(ref_sync),
      .sig_in(sig_in), .offset_out(offset_out), .valid(valid),
      .locked(locked), .period_err(period_err)
   );

   always #10 clk = ~clk;

   typedef struct {
      logic [11:0] off;
      logic        lk;
      logic        pe;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   int          stray = 0;   // period_err pulses without a capture
   int          mtmo  = 0;   // timeouts the model predicts
   int unsigned cyc   = 0;
   int unsigned last_cyc = 0;
   int          mcnt  = 0;
   logic        mhalf = 1'b0;
   logic        mfirst = 1'b1;
   int          mlc   = 0;

   // Reference counter model.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rst || ref_sync) begin
         mcnt  <= 0;
         mhalf <= 1'b0;
      end else if (mcnt == 624) begin
         mcnt  <= 0;
         mhalf <= ~mhalf;
      end else begin
         mcnt  <= mcnt + 1;
      end
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog got no finish want finish");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      assert (got === exp) else begin
         bad++;
         $error("FAIL %s got=%0h want=%0h", tag, got, exp);
      end
   endtask

   // One cycle; outputs sampled at the falling edge.
   task automatic tick();
      exp_t e;
      @(negedge clk);
      if (!rst) begin
         if (valid) begin
            total++;
            assert (q.size() > 0) else begin
               bad++;
               $error("FAIL stray_valid got=1 want=0");
            end
            if (q.size() > 0) begin
               e = q.pop_front();
               chk("offset", 32'(offset_out), 32'(e.off));
               chk("locked_at_valid", 32'(locked), 32'(e.lk));
               chk("perr_at_valid", 32'(period_err), 32'(e.pe));
            end
         end
         if (period_err && !valid) stray++;
      end
   endtask

   task automatic wait_cnt(input int c, input logic h);
      int n = 0;
      while (!(mcnt == c && mhalf == h) && n < 3000) begin
         tick();
         n++;
      end
      chk("wait_bound", 32'(n < 3000), 32'd1);
   endtask

   task automatic wait_cyc(input int unsigned t);
      while (cyc < t) tick();
   endtask

   // Raise sig_in in the current cycle (this is the true edge cycle).
   task automatic do_rise();
      exp_t e;
      logic [9:0] c10;
      int per;
      per = int'(cyc - last_cyc);
      if (per >= 2 * P) begin
         mfirst = 1'b1;
         mlc    = 0;
         mtmo++;
      end
      e.pe = 1'b0;
      if (mfirst) mfirst = 1'b0;
      else if (per >= P - TOL && per <= P + TOL) begin
         if (mlc < LOCKN) mlc++;
      end else begin
         mlc  = 0;
         e.pe = 1'b1;
      end
      e.lk  = (mlc == LOCKN);
      c10   = mcnt[9:0];
      e.off = {1'b1, mhalf, c10};
      q.push_back(e);
      last_cyc = cyc;
      sig_in = 1'b1;
      repeat (600) tick();
      sig_in = 1'b0;
      chk("capture_seen", 32'(q.size()), 32'd0);
   endtask

   initial begin
      // 1: reset holds everything at zero despite input activity
      repeat (3) begin
         tick();
         sig_in = ~sig_in;
      end
      sig_in = 1'b0;
      repeat (3) tick();
      chk("rst_offset", 32'(offset_out), 32'd0);
      chk("rst_valid", 32'(valid), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      chk("rst_perr", 32'(period_err), 32'd0);
      rst = 1'b0;
      last_cyc = cyc;
      wait_cnt(624, 1'b0);
      chk("cnt_top", 32'(dut.cnt), 32'd624);
      tick();
      chk("cnt_wrap", 32'(dut.cnt), 32'd0);
      chk("half_toggle", 32'(dut.half), 32'd1);

      // 2: steady 1250-tick wave at cnt=100, half=0
      for (int i = 0; i < 6; i++) begin
         wait_cnt(100, 1'b0);
         do_rise();
      end
      chk("ph100_word", 32'(offset_out), 32'h864);
      chk("lock_after_5", 32'(locked), 32'd1);

      // 3: other phases, including the compensation borrow
      wait_cnt(300, 1'b1); do_rise();
      wait_cnt(300, 1'b1); do_rise();
      chk("ph300_word", 32'(offset_out), 32'hD2C);
      wait_cnt(624, 1'b0); do_rise();
      chk("borrow_word", 32'(offset_out), 32'hA70);
      wait_cnt(0, 1'b1); do_rise();
      chk("ph0h1_word", 32'(offset_out), 32'hC00);

      // 4: relock, bad period, relock, tolerated period
      for (int i = 0; i < 5; i++) begin
         wait_cnt(100, 1'b0);
         do_rise();
      end
      chk("relock", 32'(locked), 32'd1);
      wait_cnt(110, 1'b0); do_rise();
      chk("bad1260_unlock", 32'(locked), 32'd0);
      for (int i = 0; i < 4; i++) begin
         wait_cnt(110, 1'b0);
         do_rise();
      end
      chk("relock_4", 32'(locked), 32'd1);
      wait_cnt(114, 1'b0); do_rise();
      chk("p1254_keeps", 32'(locked), 32'd1);

      // 5: input stops -> single timeout pulse about 2*P after the last edge
      wait_cyc(last_cyc + 2490);
      chk("pre_timeout_lock", 32'(locked), 32'd1);
      chk("pre_timeout_perr", 32'(stray), 32'd0);
      wait_cyc(last_cyc + 2520);
      chk("timeout_unlock", 32'(locked), 32'd0);
      chk("timeout_pulses", 32'(stray), 32'd1);
      wait_cnt(75, 1'b1); do_rise();
      chk("after_timeout_pulses", 32'(stray), 32'd1);

      // 6: ref_sync on a wrap cycle while locked
      for (int i = 0; i < 4; i++) begin
         wait_cnt(75, 1'b1);
         do_rise();
      end
      chk("lock_before_sync", 32'(locked), 32'd1);
      wait_cnt(624, 1'b0);
      ref_sync = 1'b1;
      tick();
      ref_sync = 1'b0;
      chk("sync_cnt", 32'(dut.cnt), 32'd0);
      chk("sync_half", 32'(dut.half), 32'd0);
      chk("sync_keeps_lock", 32'(locked), 32'd1);
      wait_cyc(last_cyc + P); do_rise();
      chk("shifted_word", 32'(offset_out), 32'h84B);
      wait_cyc(last_cyc + P); do_rise();
      chk("lock_after_sync", 32'(locked), 32'd1);
      chk("model_timeouts", 32'(stray), 32'(mtmo));

      // reset mid-period clears outputs at once
      repeat (300) tick();
      #3 rst = 1'b1;
      #1;
      chk("midrst_offset", 32'(offset_out), 32'd0);
      chk("midrst_valid", 32'(valid), 32'd0);
      chk("midrst_locked", 32'(locked), 32'd0);
      chk("midrst_perr", 32'(period_err), 32'd0);
      q.delete();
      mfirst = 1'b1;
      mlc    = 0;
      repeat (3) tick();
      rst = 1'b0;
      last_cyc = cyc;
      for (int i = 0; i < 2; i++) begin
         wait_cnt(100, 1'b0);
         do_rise();
      end
      chk("post_rst_unlocked", 32'(locked), 32'd0);
      chk("post_rst_word", 32'(offset_out), 32'h864);
      chk("final_pulses", 32'(stray), 32'(mtmo));

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
